// File: rtl/gpio_in_debounce.sv
// Purpose: synchronise and debounce the board button and switches, emit clean levels plus one-cycle edge pulses.
// Latency: 2 sync cycles + 1 register cycle + STABLE_CNT sample ticks, i.e. (STABLE_CNT-1)*TICK_DIV+3 .. STABLE_CNT*TICK_DIV+2 cycles.
// Backpressure: none; levels and pulses are free-running and sampled by the consumer every cycle.
module gpio_in_debounce #(
  parameter int SW_WIDTH   = 16,
  parameter int TICK_DIV   = 100000,
  parameter int STABLE_CNT = 4
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                btn_i,
  input  logic [SW_WIDTH-1:0] sw_i,
  output logic                btn_o,
  output logic                btn_press_o,
  output logic                btn_release_o,
  output logic [SW_WIDTH-1:0] sw_o,
  output logic                sw_change_o
);

  // Bit 0 is the button, bits [SW_WIDTH:1] are the switches.
  localparam int N  = SW_WIDTH + 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(STABLE_CNT - 1);

  logic [N-1:0]  pin;
  logic [N-1:0]  s1;
  logic [N-1:0]  s2;
  logic [N-1:0]  level;
  logic [N-1:0]  level_nxt;
  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic [CW-1:0] db_cnt     [N];
  logic [CW-1:0] db_cnt_nxt [N];

  assign pin = {sw_i, btn_i};

  // Two-flop synchroniser for every asynchronous pin.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pin;
      s2 <= s1;
    end
  end

  // Shared prescaler; tick marks the last count of each sample period.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  assign tick = (pre_cnt == PRE_LAST);

  // Per-bit qualification: any agreeing tick restarts the count, STABLE_CNT disagreeing ticks flip the level.
  always_comb begin
    level_nxt = level;
    for (int i = 0; i < N; i++) begin
      db_cnt_nxt[i] = db_cnt[i];
      if (tick) begin
        if (s2[i] == level[i]) begin
          db_cnt_nxt[i] = '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level_nxt[i]  = s2[i];
          db_cnt_nxt[i] = '0;
        end else begin
          db_cnt_nxt[i] = db_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Level and qualification counter state.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      level <= '0;
      for (int i = 0; i < N; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      level <= level_nxt;
      for (int i = 0; i < N; i++) begin
        db_cnt[i] <= db_cnt_nxt[i];
      end
    end
  end

  // Pulses come from the next level so they line up with the first cycle the new level is visible.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      btn_press_o   <= 1'b0;
      btn_release_o <= 1'b0;
      sw_change_o   <= 1'b0;
    end else begin
      btn_press_o   <= level_nxt[0] & ~level[0];
      btn_release_o <= ~level_nxt[0] & level[0];
      sw_change_o   <= |(level_nxt[N-1:1] ^ level[N-1:1]);
    end
  end

  assign btn_o = level[0];
  assign sw_o  = level[N-1:1];

endmodule

// File: tb/tb_gpio_in_debounce.sv
module tb_gpio_in_debounce;

  localparam int SC = 3;

  logic        clk;
  logic        arst_n;
  logic        btn_i;
  logic [15:0] sw_i;

  logic        btn_o, btn_press_o, btn_release_o, sw_change_o;
  logic [15:0] sw_o;
  logic        f_btn_o, f_btn_press_o, f_btn_release_o, f_sw_change_o;
  logic [15:0] f_sw_o;

  int tests = 0;
  int fails = 0;

  // pulse / change counters for the TICK_DIV=4 instance
  int          np, nr, nc, nsw;
  logic [15:0] prev_sw;

  gpio_in_debounce #(.SW_WIDTH(16), .TICK_DIV(4), .STABLE_CNT(SC)) u_dut (
    .clk_i        (clk),
    .arst_n_i     (arst_n),
    .btn_i        (btn_i),
    .sw_i         (sw_i),
    .btn_o        (btn_o),
    .btn_press_o  (btn_press_o),
    .btn_release_o(btn_release_o),
    .sw_o         (sw_o),
    .sw_change_o  (sw_change_o)
  );

  gpio_in_debounce #(.SW_WIDTH(16), .TICK_DIV(1), .STABLE_CNT(SC)) u_fast (
    .clk_i        (clk),
    .arst_n_i     (arst_n),
    .btn_i        (btn_i),
    .sw_i         (sw_i),
    .btn_o        (f_btn_o),
    .btn_press_o  (f_btn_press_o),
    .btn_release_o(f_btn_release_o),
    .sw_o         (f_sw_o),
    .sw_change_o  (f_sw_change_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: index 0 = TICK_DIV 4, index 1 = TICK_DIV 1.
  logic [16:0] m_p1, m_p2;
  logic [16:0] m_lvl [2];
  int          m_run [2][17];
  int          m_cyc [2];
  logic        m_press [2];
  logic        m_rel [2];
  logic        m_chg [2];
  logic [16:0] m_old;
  int          m_td;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_p1 = '0;
      m_p2 = '0;
      for (int m = 0; m < 2; m++) begin
        m_lvl[m] = '0; m_cyc[m] = 0;
        m_press[m] = 0; m_rel[m] = 0; m_chg[m] = 0;
        for (int i = 0; i < 17; i++) m_run[m][i] = 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        m_td  = (m == 0) ? 4 : 1;
        m_old = m_lvl[m];
        if ((m_cyc[m] % m_td) == m_td - 1) begin
          for (int i = 0; i < 17; i++) begin
            if (m_p2[i] == m_lvl[m][i]) m_run[m][i] = 0;
            else begin
              m_run[m][i]++;
              if (m_run[m][i] == SC) begin
                m_lvl[m][i] = m_p2[i];
                m_run[m][i] = 0;
              end
            end
          end
        end
        m_press[m] = m_lvl[m][0] & ~m_old[0];
        m_rel[m]   = ~m_lvl[m][0] & m_old[0];
        m_chg[m]   = (m_lvl[m][16:1] != m_old[16:1]);
        m_cyc[m]++;
      end
      m_p2 = m_p1;
      m_p1 = {sw_i, btn_i};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("btn_o",           {31'd0, btn_o},           {31'd0, m_lvl[0][0]});
    chk("btn_press_o",     {31'd0, btn_press_o},     {31'd0, m_press[0]});
    chk("btn_release_o",   {31'd0, btn_release_o},   {31'd0, m_rel[0]});
    chk("sw_o",            {16'd0, sw_o},            {16'd0, m_lvl[0][16:1]});
    chk("sw_change_o",     {31'd0, sw_change_o},     {31'd0, m_chg[0]});
    chk("f_btn_o",         {31'd0, f_btn_o},         {31'd0, m_lvl[1][0]});
    chk("f_btn_press_o",   {31'd0, f_btn_press_o},   {31'd0, m_press[1]});
    chk("f_btn_release_o", {31'd0, f_btn_release_o}, {31'd0, m_rel[1]});
    chk("f_sw_o",          {16'd0, f_sw_o},          {16'd0, m_lvl[1][16:1]});
    chk("f_sw_change_o",   {31'd0, f_sw_change_o},   {31'd0, m_chg[1]});
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_all();
      if (btn_press_o)     np++;
      if (btn_release_o)   nr++;
      if (sw_change_o)     nc++;
      if (sw_o !== prev_sw) nsw++;
      prev_sw = sw_o;
    end
  endtask

  task automatic clr();
    np = 0; nr = 0; nc = 0; nsw = 0;
    prev_sw = sw_o;
  endtask

  int lat, lat_f, r;

  initial begin
    arst_n = 1'b0;
    btn_i  = 1'b1;
    sw_i   = 16'hFFFF;
    prev_sw = '0;
    np = 0; nr = 0; nc = 0; nsw = 0;

    // Reset with all pins high: outputs held at 0
    step(3);
    chk("rst_btn_o", {31'd0, btn_o}, 32'd0);
    chk("rst_sw_o", {16'd0, sw_o}, 32'd0);
    chk("rst_press", {31'd0, btn_press_o}, 32'd0);
    chk("rst_chg", {31'd0, sw_change_o}, 32'd0);

    // Release: pins held high are accepted within 14 cycles
    arst_n = 1'b1;
    clr();
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      step(1);
      if (lat < 0 && btn_o === 1'b1) lat = n;
    end
    chk("rst_accept_lat", {31'd0, (lat >= 1 && lat <= 14)}, 32'd1);
    chk("rst_btn_after", {31'd0, btn_o}, 32'd1);
    chk("rst_sw_after", {16'd0, sw_o}, 32'h0000FFFF);
    chk("rst_press_cnt", np, 32'd1);
    chk("rst_chg_cnt", nc, 32'd1);

    // Settle low
    btn_i = 1'b0;
    sw_i  = 16'h0000;
    step(30);
    chk("settle_btn", {31'd0, btn_o}, 32'd0);
    chk("settle_sw", {16'd0, sw_o}, 32'd0);

    // Clean press: 11..14 cycles, press pulse on the first high cycle
    clr();
    btn_i = 1'b1;
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      step(1);
      if (lat < 0 && btn_o === 1'b1) begin
        lat = n;
        chk("press_same_cycle", {31'd0, btn_press_o}, 32'd1);
      end
    end
    chk("press_lat_range", {31'd0, (lat >= 11 && lat <= 14)}, 32'd1);
    chk("press_cnt", np, 32'd1);
    chk("press_no_release", nr, 32'd0);

    // Release
    clr();
    btn_i = 1'b0;
    step(30);
    chk("rel_btn_o", {31'd0, btn_o}, 32'd0);
    chk("rel_cnt", nr, 32'd1);
    chk("rel_no_press", np, 32'd0);

    // Bounce: 2-tick high glitch is rejected
    clr();
    btn_i = 1'b1;
    step(8);
    btn_i = 1'b0;
    step(30);
    chk("bounce_btn_o", {31'd0, btn_o}, 32'd0);
    chk("bounce_press", np, 32'd0);
    chk("bounce_release", nr, 32'd0);
    btn_i = 1'b1;
    step(30);
    chk("after_bounce_btn_o", {31'd0, btn_o}, 32'd1);
    chk("after_bounce_press", np, 32'd1);
    btn_i = 1'b0;
    step(30);

    // Multi-bit switch change: one update, one pulse
    clr();
    sw_i = 16'hA5A5;
    step(30);
    chk("sw_multi_val", {16'd0, sw_o}, 32'h0000A5A5);
    chk("sw_multi_pulse", nc, 32'd1);
    chk("sw_multi_updates", nsw, 32'd1);

    // Reset mid-qualification restarts counting from release
    btn_i = 1'b1;
    step(8);
    chk("midq_btn_o", {31'd0, btn_o}, 32'd0);
    arst_n = 1'b0;
    step(1);
    chk("midq_rst_btn", {31'd0, btn_o}, 32'd0);
    chk("midq_rst_fbtn", {31'd0, f_btn_o}, 32'd0);
    arst_n = 1'b1;
    lat = -1;
    lat_f = -1;
    for (int n = 1; n <= 40; n++) begin
      step(1);
      if (lat < 0 && btn_o === 1'b1) lat = n;
      if (lat_f < 0 && f_btn_o === 1'b1) lat_f = n;
    end
    chk("midq_lat_div4", lat, 32'd12);
    chk("midq_lat_div1", lat_f, 32'd5);

    // Randomised glitches, switch flips and occasional resets against the model
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 99);
      if (r < 40) btn_i = ~btn_i;
      else if (r < 65) sw_i = sw_i ^ (16'd1 << $urandom_range(0, 15));
      else if (r < 80) sw_i = 16'($urandom);
      else if (r < 83) begin
        arst_n = 1'b0;
        step(1);
        arst_n = 1'b1;
      end
      step($urandom_range(1, 20));
    end
    step(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
